// File: rtl/window_gen_5x5_pkg.sv
// ============================================================================
// window_gen_5x5_pkg : shared window geometry and o_win packing index. Rev 1.0
// ============================================================================
`default_nettype none

package window_gen_5x5_pkg;

  localparam int WIN    = 5;
  localparam int NUM_LB = WIN - 1;

  // Slot of pixel (r, c) inside the packed 25-pixel window; the filter wrapper
  // unpacks with the same function, so both sides always agree on ordering.
  function automatic int win_idx(input int r, input int c);
    return r * WIN + c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/window_gen_5x5_line_buffer.sv
// ============================================================================
// line_buffer : single-port read-before-write line store, one image line deep. Rev 1.0
// ============================================================================
`default_nettype none

module line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Asynchronous read returns the old word in the same cycle it is overwritten.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/window_gen_5x5.sv
// ============================================================================
// window_gen_5x5 : raster stream to 5x5 valid-region sliding window. Rev 1.0
// ============================================================================
`default_nettype none

module window_gen_5x5
  import window_gen_5x5_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  input  logic                         i_sof,
  input  logic signed [DATA_WIDTH-1:0] i_x,
  output logic                         o_valid,
  output logic [25*DATA_WIDTH-1:0]     o_win,
  output logic                         o_frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_VALID = CW'(WIN - 1);
  localparam logic [RW-1:0] ROW_VALID = RW'(WIN - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;

  logic [DATA_WIDTH-1:0] lb_rd    [NUM_LB];
  logic [DATA_WIDTH-1:0] lb_wd    [NUM_LB];
  logic [DATA_WIDTH-1:0] col_data [WIN];

  // Start-of-frame forces the accepted pixel to (0,0) regardless of counters.
  assign cur_col = i_sof ? '0 : col;
  assign cur_row = i_sof ? '0 : row;

  generate
    for (genvar k = 0; k < NUM_LB; k++) begin : g_lb
      if (k == 0) begin : g_head
        assign lb_wd[k] = i_x;
      end else begin : g_chain
        assign lb_wd[k] = lb_rd[k-1];
      end

      line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH)
      ) u_lb (
        .clk   (clk),
        .we    (i_valid),
        .addr  (cur_col),
        .wdata (lb_wd[k]),
        .rdata (lb_rd[k])
      );
    end

    // Oldest line (lb3) lands in window row 0, the live pixel in row 4.
    for (genvar r = 0; r < WIN; r++) begin : g_col
      if (r == WIN - 1) begin : g_live
        assign col_data[r] = i_x;
      end else begin : g_stored
        assign col_data[r] = lb_rd[NUM_LB-1-r];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      o_win        <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_valid) begin
        o_valid <= (cur_row >= ROW_VALID) && (cur_col >= COL_VALID);
        for (int r = 0; r < WIN; r++) begin
          for (int c = 0; c < WIN - 1; c++) begin
            o_win[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] <=
              o_win[win_idx(r, c + 1)*DATA_WIDTH +: DATA_WIDTH];
          end
          o_win[win_idx(r, WIN - 1)*DATA_WIDTH +: DATA_WIDTH] <= col_data[r];
        end
        if (cur_col == COL_LAST) begin
          col <= '0;
          if (cur_row == ROW_LAST) begin
            row          <= '0;
            o_frame_done <= 1'b1;
          end else begin
            row <= cur_row + 1'b1;
          end
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_window_gen_5x5.sv
// ============================================================================
// tb_window_gen_5x5 : scoreboard bench for window_gen_5x5 on an 8x6 image. Rev 1.0
// ============================================================================
`default_nettype none

module tb_window_gen_5x5;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_valid = 1'b0;
  logic              i_sof = 1'b0;
  logic signed [DW-1:0] i_x = '0;
  logic              o_valid;
  logic [25*DW-1:0]  o_win;
  logic              o_frame_done;

  window_gen_5x5 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_sof        (i_sof),
    .i_x          (i_x),
    .o_valid      (o_valid),
    .o_win        (o_win),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [25*DW-1:0] exp_q [$];
  int               fd_at [$];
  int               exp_fd = 0;
  int               fd_count = 0;
  int               win_count = 0;
  int               acc_count = 0;
  int               consec = 0;
  int               hold_errs = 0;
  bit               gapped = 1'b0;
  bit               prev_valid = 1'b0;
  bit               prev_acc = 1'b0;
  logic [25*DW-1:0] prev_win = '0;
  logic [25*DW-1:0] first_win = '0;
  logic [25*DW-1:0] last_win = '0;

  task automatic check(input string name, input logic [25*DW-1:0] act, input logic [25*DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input bit neg, input int r, input int c);
    int v;
    v = r * W + c;
    return neg ? DW'(-v) : DW'(v);
  endfunction

  function automatic logic [DW-1:0] slot(input logic [25*DW-1:0] w, input int r, input int c);
    return w[(r*5+c)*DW +: DW];
  endfunction

  always @(posedge clk) if (i_valid && !rst) acc_count++;

  // Monitor: pops one expected window per o_valid, independent of the driver.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {24'd0, 8'd1}, '0);
        end else begin
          check("window", o_win, exp_q.pop_front());
        end
        win_count++;
        if (win_count == 1) first_win = o_win;
        last_win = o_win;
      end
      if (o_frame_done) begin
        fd_count++;
        fd_at.push_back(acc_count);
      end
      if (gapped && o_valid && prev_valid) consec++;
      if (!prev_acc && o_win !== prev_win) hold_errs++;
      prev_valid = o_valid;
    end
    prev_win = o_win;
    prev_acc = i_valid && !rst;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_pixel(input logic [DW-1:0] v, input bit sof);
    i_valid = 1'b1; i_sof = sof; i_x = v;
    @(posedge clk); #1;
    i_valid = 1'b0; i_sof = 1'b0;
  endtask

  // Drives npix pixels of a frame; the expected window is built from the
  // pixel coordinates, not from anything the DUT reports.
  task automatic send_frame(input bit neg, input bit gap, input bit sof_first, input int npix);
    logic [25*DW-1:0] e;
    int n;
    n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < npix) begin
          if (r >= 4 && c >= 4) begin
            for (int rr = 0; rr < 5; rr++)
              for (int cc = 0; cc < 5; cc++)
                e[(rr*5+cc)*DW +: DW] = pix(neg, r - 4 + rr, c - 4 + cc);
            exp_q.push_back(e);
          end
          if (r == H - 1 && c == W - 1) exp_fd++;
          send_pixel(pix(neg, r, c), sof_first && r == 0 && c == 0);
          if (gap) idle(1);
          n++;
        end
      end
    end
  endtask

  task automatic finish_scenario(input string name, input int exp_wins);
    idle(3);
    check({name, "_win_count"}, 200'(win_count), 200'(exp_wins));
    check({name, "_queue_empty"}, 200'(exp_q.size()), '0);
    check({name, "_frame_done_count"}, 200'(fd_count), 200'(exp_fd));
    win_count = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    check("reset_valid", 200'(o_valid), '0);
    check("reset_frame_done", 200'(o_frame_done), '0);
    check("reset_win", o_win, '0);
    rst = 1'b0;
    idle(1);

    // Full frame, continuous.
    send_frame(1'b0, 1'b0, 1'b1, W * H);
    finish_scenario("full", 8);
    check("full_x00", 200'(slot(first_win, 0, 0)), 200'(8'd0));
    check("full_x22", 200'(slot(first_win, 2, 2)), 200'(8'd18));
    check("full_x44", 200'(slot(first_win, 4, 4)), 200'(8'd36));
    check("full_x04", 200'(slot(first_win, 0, 4)), 200'(8'd4));
    check("full_x40", 200'(slot(first_win, 4, 0)), 200'(8'd32));
    check("full_last_x44", 200'(slot(last_win, 4, 4)), 200'(8'd47));

    // Alternate-cycle input.
    gapped = 1'b1;
    send_frame(1'b0, 1'b1, 1'b1, W * H);
    gapped = 1'b0;
    finish_scenario("gapped", 8);
    check("gapped_no_consecutive", 200'(consec), '0);
    check("gapped_win_hold", 200'(hold_errs), '0);

    // Abandoned partial frame followed by a fresh i_sof frame.
    send_frame(1'b0, 1'b0, 1'b1, 20);
    send_frame(1'b0, 1'b0, 1'b1, W * H);
    finish_scenario("restart", 8);

    // Reset after pixel 40, then a frame without i_sof.
    send_frame(1'b0, 1'b0, 1'b1, 41);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", 200'(o_valid), '0);
    check("midrst_frame_done", 200'(o_frame_done), '0);
    check("midrst_win", o_win, '0);
    finish_scenario("midrst_partial", 4);
    send_frame(1'b0, 1'b0, 1'b0, W * H);
    finish_scenario("midrst_after", 8);

    // Two frames back to back, only the first marked.
    send_frame(1'b0, 1'b0, 1'b1, W * H);
    send_frame(1'b0, 1'b0, 1'b0, W * H);
    finish_scenario("b2b", 16);
    if (fd_at.size() >= 2)
      check("b2b_fd_spacing", 200'(fd_at[fd_at.size()-1] - fd_at[fd_at.size()-2]), 200'(48));
    else
      check("b2b_fd_entries", 200'(fd_at.size()), 200'(2));

    // Negative pixel values.
    send_frame(1'b1, 1'b0, 1'b1, W * H);
    finish_scenario("neg", 8);
    check("neg_x44", 200'(slot(first_win, 4, 4)), 200'(8'hDC));
    check("neg_x00", 200'(slot(first_win, 0, 0)), 200'(8'h00));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/window_gen_5x5.md
Name: window_gen_5x5

Overview:
- Upstream neighbour of the 5x5 filter multiply stage. Accepts a raster-order pixel stream, one pixel per accepted cycle.
- Holds the last four image lines in line buffers and keeps a 5x5 sliding window of registers.
- Presents the full 25-pixel window, plus a valid strobe, that drives the filter's pixel inputs and enable.
- Valid-region only: windows touching the image border are suppressed, with no padding.

Parameters:
- DATA_WIDTH, 8: pixel width, signed; matches the filter input data width.
- IMG_WIDTH, 640: pixels per line, must be >= 5.
- IMG_HEIGHT, 480: lines per frame, must be >= 5.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  reset: synchronous, active-high.
- i_valid  input  1  pixel strobe; i_x is accepted on any cycle where i_valid=1.
- i_sof  input  1  start of frame; qualified by i_valid; marks the accepted pixel as (row 0, col 0).
- i_x  input  DATA_WIDTH  signed pixel.
- o_valid  output  1  window valid; drives filter i_en.
- o_win  output  25*DATA_WIDTH  packed window; o_win[(r*5+c)*DATA_WIDTH +: DATA_WIDTH] = x_rc.
  - r=0 is the oldest row, r=4 the current row.
  - c=0 is the leftmost (oldest) column, c=4 the newest column.
- o_frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset values:
  - col, row = 0.
  - All 25 window registers = 0.
  - o_valid = 0, o_frame_done = 0.
  - Line-buffer contents are not reset; o_valid gating makes stale contents irrelevant.
- Counters:
  - col is 0..IMG_WIDTH-1 and row is 0..IMG_HEIGHT-1, each $clog2 wide.
  - Both advance only on accepted pixels.
  - col wraps to 0 and increments row; after (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0 and o_frame_done pulses the next cycle.
- i_sof with i_valid: the current pixel is treated as (0,0), overriding the counter values. Any partial frame in progress is abandoned without o_frame_done. Window contents are not cleared; gating suppresses output.
- Line buffers: four buffers lb0..lb3, each IMG_WIDTH x DATA_WIDTH, addressed by col. On an accepted pixel, read before write at the same address:
  - Read column = {lb3[col], lb2[col], lb1[col], lb0[col], i_x}, giving rows r-4..r.
  - Writes: lb3<=lb2[col], lb2<=lb1[col], lb1<=lb0[col], lb0<=i_x.
- Window: on an accepted pixel, each row shifts left (c0<=c1 .. c3<=c4) and the read column loads into c4, row-aligned (lb3 value into r=0, i_x into r=4).
- Output timing:
  - o_valid <= (row>=4 && col>=4), registered using the pre-increment counter values of the accepted pixel.
  - Latency: 1 cycle from accept to o_valid/o_win.
  - o_valid=0 on any cycle following a non-accept cycle.
  - o_win holds its value when there is no accept.
- Window centre: x22 is pixel (row-2, col-2). Outputs per frame = (IMG_WIDTH-4)*(IMG_HEIGHT-4).
- Line wrap: at col 0..3 the window contains the previous line's tail, but o_valid=0 there.
- Back-to-back frames without i_sof are legal; counter wrap defines the frame boundary.
- Stalls: i_valid gaps of any length change nothing except forcing o_valid=0. There is no backpressure input; the downstream stage is always ready.
- Reset mid-frame: clears counters, window and outputs in the same cycle. The next accepted pixel is (0,0) regardless of i_sof.
- Reset has priority over i_valid.

Decomposition:
- Shared package holds:
  - the window size constant (5);
  - a localparam for the number of line buffers (4);
  - the index function (r*5+c) for o_win packing, used identically here and by the filter wrapper that unpacks o_win onto the filter's 25 pixel inputs.
- One sub-module: line_buffer.
  - Single-port, read-before-write, depth IMG_WIDTH, write-enable = accept.
  - Inferable as block RAM with registered output, or as registers.
  - If a RAM with 1-cycle read is used, a column-alignment stage is added and the total latency stays documented at 1 cycle after the RAM read.
  - Instantiated four times.

Test Plan:
- Full frame: IMG_WIDTH=8, IMG_HEIGHT=6, i_x=row*8+col, continuous i_valid, i_sof on the first pixel.
  - First o_valid one cycle after pixel 36 is accepted, with x00=0, x22=18, x44=36, x04=4, x40=32.
  - Exactly 8 o_valid pulses; the last has x44=47.
  - o_frame_done pulses once, after pixel 47.
- Gapped input: same frame with i_valid=1 on alternate cycles.
  - Identical 8 windows in the same order.
  - o_valid never high on two consecutive cycles.
- Mid-frame restart: after 20 pixels, assert i_sof and send a fresh frame.
  - No o_valid from the first attempt.
  - The second frame yields exactly 8 windows matching the full-frame scenario.
  - No o_frame_done for the aborted frame.
- Reset mid-frame: assert rst for 1 cycle after pixel 40.
  - Next cycle o_valid=0, o_frame_done=0, o_win=0.
  - A subsequent frame sent without i_sof still yields the 8 correct windows.
- Back-to-back frames: two frames with no gap and no second i_sof.
  - 16 valid windows, the second set identical to the first.
  - Two o_frame_done pulses, 48 accepts apart.
- Negative data: i_x = -(row*8+col) (signed).
  - First window has x44=-36 and x00=0.
  - Confirms no sign or width corruption through the line buffers.
